alu_or_expand_pipe: RTL and testbench



---
 rtl/alu_or_expand_pipe.sv | 90 +++++++++
 tb/tb_alu_or_expand_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_or_expand_pipe.sv
// Two-stage segment-flag expander: broadcasts each segment LSB across its segment.
// Optional completed-handshake counter enabled by ALU_OR_EXPAND_CNT_EN.
module alu_or_expand_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
  input  logic [2:0]  funct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        err,
  output logic [15:0] out_count
);

  logic        s1_valid;
  logic [31:0] s1_din;
  logic [2:0]  s1_funct;
  logic        adv;
  logic [31:0] x2, x4, x8, x16;
  logic [31:0] exp_d;
  logic        exp_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_din   <= '0;
      s1_funct <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_din   <= din;
      s1_funct <= funct;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_exp
    assign x2[i]  = s1_din[i - (i % 2)];
    assign x4[i]  = s1_din[i - (i % 4)];
    assign x8[i]  = s1_din[i - (i % 8)];
    assign x16[i] = s1_din[i - (i % 16)];
  end

  always_comb begin
    exp_d   = s1_din;
    exp_err = 1'b0;
    case (s1_funct)
      3'd0: exp_d = s1_din;
      3'd1: exp_d = x2;
      3'd2: exp_d = x4;
      3'd3: exp_d = x8;
      3'd4: exp_d = x16;
      default: begin
        exp_d   = 32'hDEAD_BEEF;
        exp_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      err       <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= exp_d;
        err  <= exp_err;
      end
    end
  end

`ifdef ALU_OR_EXPAND_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_count <= '0;
    else if (out_valid && out_ready)
      out_count <= out_count + 16'd1;
  end
`else
  assign out_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_or_expand_pipe.sv
// Scoreboard bench for alu_or_expand_pipe: directed cases plus random
// traffic with random backpressure, checked against a reference model.
module tb_alu_or_expand_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] din = '0;
  logic [2:0]  funct = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] dout;
  logic        err;
  logic [15:0] out_count;

  alu_or_expand_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .err(err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q[$];
  exp_t        got;
  int          errors = 0;
  int          checks = 0;
  int          pushes = 0;
  int          pops = 0;
  logic [15:0] cnt_model = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_dout = '0;
  logic        prev_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment width W = 2^funct; every bit copies the LSB of its segment.
  function automatic exp_t model(input logic [31:0] d, input logic [2:0] f);
    exp_t r;
    int w;
    r.d = '0;
    r.e = 1'b0;
    if (f > 3'd4) begin
      r.d = 32'hDEAD_BEEF;
      r.e = 1'b1;
    end else if (f == 3'd0) begin
      r.d = d;
    end else begin
      w = 1 << f;
      for (int i = 0; i < 32; i++) r.d[i] = d[(i / w) * w];
    end
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      q.push_back(model(din, funct));
      pushes++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_dout", dout, prev_dout);
        chk("hold_err", {31'd0, err}, {31'd0, prev_err});
      end
      chk("out_count", {16'd0, out_count}, {16'd0, cnt_model});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", dout);
        end else begin
          got = q.pop_front();
          chk("dout", dout, got.d);
          chk("err", {31'd0, err}, {31'd0, got.e});
        end
        pops++;
`ifdef ALU_OR_EXPAND_CNT_EN
        cnt_model = cnt_model + 16'd1;
`endif
      end
      prev_hold = out_valid && !out_ready;
      prev_dout = dout;
      prev_err  = err;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [2:0] f);
    int n = 0;
    in_valid = 1'b1;
    din      = d;
    funct    = f;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    q.delete();
    cnt_model = '0;
    pushes = 0;
    pops = 0;
    in_valid = 1'b0;
    repeat (2) sync;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_out_count", {16'd0, out_count}, 32'd0);
    sync;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // single word and latency
    sync;
    out_ready = 1'b1;
    put(32'h0100_0001, 3'b011);
    @(negedge clk);
    chk("lat_s1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_s2", {31'd0, out_valid}, 32'd1);
    chk("single_dout", dout, 32'hFF00_00FF);

    // back-to-back stream
    sync;
    put(32'h0000_0005, 3'b001);
    put(32'h1111_1110, 3'b010);
    put(32'hFFFE_0001, 3'b100);
    put(32'h1234_5678, 3'b000);
    @(negedge clk);
    chk("stream_v0", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("stream_v1", {31'd0, out_valid}, 32'd1);
    chk("stream_last", dout, 32'h1234_5678);
    @(negedge clk);
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    // illegal funct then legal
    sync;
    put(32'hFFFF_FFFF, 3'b110);
    put(32'h0000_0001, 3'b010);
    repeat (4) sync;

    // backpressure
    out_ready = 1'b0;
    put(32'h0000_0041, 3'b001);
    put(32'h0001_0010, 3'b010);
    in_valid = 1'b1;
    din      = 32'h8000_0100;
    funct    = 3'b011;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    sync;
    out_ready = 1'b1;
    put(32'h8000_0100, 3'b011);
    repeat (5) sync;
    chk("bp_drained", q.size(), 32'd0);
    chk("bp_no_loss", pops, pushes);

    // reset with both stages full
    out_ready = 1'b0;
    put(32'h0000_0003, 3'b001);
    put(32'h0000_0007, 3'b010);
    do_reset;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      sync;
      in_valid  = ($urandom_range(0, 3) != 0);
      din       = $urandom;
      funct     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    sync;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) sync;
    chk("rand_drained", q.size(), 32'd0);
    chk("rand_no_loss", pops, pushes);

`ifdef ALU_OR_EXPAND_CNT_EN
    do_reset;
    sync;
    out_ready = 1'b1;
    for (int c = 0; c < 70000 && pops < 65537; c++) begin
      in_valid = (pushes < 65537);
      din      = $urandom;
      funct    = 3'($urandom_range(0, 7));
      sync;
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_pops", pops, 32'd65537);
    chk("wrap_count", {16'd0, out_count}, 32'd1);
`else
    @(negedge clk);
    chk("count_disabled", {16'd0, out_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
